// File: rtl/xor_stream_descrambler_if.sv
// xor_stream_descrambler_if: seed control, byte input/output handshakes and status of the descrambler.
interface xor_stream_descrambler_if #(
    parameter int DATA_W = 8,
    parameter int LFSR_W = 16
);
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       byte_cnt;
    logic              seeded;

    modport master (
        output seed_load, seed_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, byte_cnt, seeded
    );
    modport slave (
        input  seed_load, seed_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, byte_cnt, seeded
    );
endinterface

// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: XORs each accepted byte with 8 Galois-LFSR keystream bits into a registered output.
// Defining DESCR_BYPASS_EN adds a bypass input that passes bytes through without advancing the LFSR.
module xor_stream_descrambler #(
    parameter int                DATA_W       = 8,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
    input logic clk,
    input logic rst,
`ifdef DESCR_BYPASS_EN
    input logic bypass,
`endif
    xor_stream_descrambler_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_adv;
    logic [DATA_W-1:0] ks, out_data;
    logic [15:0] byte_cnt;
    logic out_valid, in_ready, accept, pass;

`ifdef DESCR_BYPASS_EN
    assign pass = bypass;
`else
    assign pass = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb state_nxt = bus.seed_load ? RUN : state;

    always_comb begin
        in_ready = (state == RUN) && !bus.seed_load && (!out_valid || bus.out_ready);
        bus.seeded = state == RUN;
    end

    // Eight LFSR steps unrolled; keystream bit i is the LSB before step i.
    always_comb begin
        lfsr_adv = lfsr;
        ks = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ks[i] = lfsr_adv[0];
            lfsr_adv = (lfsr_adv >> 1) ^ (lfsr_adv[0] ? LFSR_TAPS : '0);
        end
    end

    assign accept = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            lfsr <= SEED_DEFAULT;
            byte_cnt <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
        end else begin
            if (bus.seed_load) begin
                lfsr <= (bus.seed_in == '0) ? SEED_DEFAULT : bus.seed_in;
                byte_cnt <= '0;
            end else if (accept) begin
                lfsr <= pass ? lfsr : lfsr_adv;
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (accept) out_data <= pass ? bus.in_data : bus.in_data ^ ks;
            out_valid <= accept ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid);
        end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data = out_data;
    assign bus.byte_cnt = byte_cnt;
endmodule

// File: tb/tb_xor_stream_descrambler.sv
// tb_xor_stream_descrambler: directed and random stimulus against a bit-serial keystream reference model.
module tb_xor_stream_descrambler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [15:0] m_lfsr, m_cnt;
    logic [7:0] m_od;
    logic m_ov, m_run;

    xor_stream_descrambler_if bus();
    xor_stream_descrambler dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Keystream byte generated one bit at a time, returning the LFSR state left behind.
    function automatic logic [7:0] keystream(input logic [15:0] s, output logic [15:0] after);
        logic [7:0] k = 8'h00;
        for (int b = 0; b < 8; b++) begin
            k[b] = s[0];
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
        after = s;
        return k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_lfsr = 16'hACE1;
        m_cnt = 16'h0000;
        m_od = 8'h00;
        m_ov = 1'b0;
        m_run = 1'b0;
    endtask

    task automatic cyc(input logic sl, input logic [15:0] si, input logic iv,
                       input logic [7:0] id, input logic ordy);
        logic exp_rdy, acc;
        logic [15:0] nl;
        logic [7:0] ks;
        @(negedge clk);
        bus.seed_load = sl;
        bus.seed_in = si;
        bus.in_valid = iv;
        bus.in_data = id;
        bus.out_ready = ordy;
        #1;
        exp_rdy = m_run && !sl && (!m_ov || ordy);
        chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
        @(posedge clk);
        acc = iv && exp_rdy;
        if (sl) begin
            m_lfsr = (si == 16'h0000) ? 16'hACE1 : si;
            m_cnt = 16'h0000;
            m_run = 1'b1;
        end
        if (acc) begin
            ks = keystream(m_lfsr, nl);
            m_od = id ^ ks;
            m_lfsr = nl;
            m_cnt = m_cnt + 16'd1;
        end
        m_ov = acc ? 1'b1 : (ordy ? 1'b0 : m_ov);
        #1;
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
        chk("out_data", {24'b0, bus.out_data}, {24'b0, m_od});
        chk("byte_cnt", {16'b0, bus.byte_cnt}, {16'b0, m_cnt});
        chk("seeded", {31'b0, bus.seeded}, {31'b0, m_run});
    endtask

    initial begin
        bus.seed_load = 1'b0;
        bus.seed_in = 16'h0000;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {24'b0, bus.out_data}, 32'd0);
        chk("rst_byte_cnt", {16'b0, bus.byte_cnt}, 32'd0);
        chk("rst_seeded", {31'b0, bus.seeded}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        repeat (4) cyc(1'b0, 16'h0, 1'b1, 8'h5A, 1'b1);
        chk("idle_cnt", {16'b0, bus.byte_cnt}, 32'd0);
        // Known keystream for the default seed.
        cyc(1'b1, 16'hACE1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        chk("ks_byte0", {24'b0, bus.out_data}, 32'hE1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        chk("ks_byte1", {24'b0, bus.out_data}, 32'hC4);
        chk("cnt_two", {16'b0, bus.byte_cnt}, 32'd2);
        cyc(1'b1, 16'hACE1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'hE1, 1'b1);
        chk("round_trip0", {24'b0, bus.out_data}, 32'h00);
        cyc(1'b0, 16'h0, 1'b1, 8'hC4, 1'b1);
        chk("round_trip1", {24'b0, bus.out_data}, 32'h00);
        cyc(1'b1, 16'h0000, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        chk("zero_seed", {24'b0, bus.out_data}, 32'hE1);
        // Backpressure: the stalled byte must not advance the keystream.
        cyc(1'b1, 16'hACE1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b0);
        chk("bp_hold_data", {24'b0, bus.out_data}, 32'hE1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b0);
        chk("bp_held", {24'b0, bus.out_data}, 32'hE1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        chk("bp_second", {24'b0, bus.out_data}, 32'hC4);
        repeat (400)
            cyc($urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        cyc(1'b0, 16'h0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'h55, 1'b0);
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_seeded", {31'b0, bus.seeded}, 32'd0);
        chk("async_out_data", {24'b0, bus.out_data}, 32'd0);
        chk("async_byte_cnt", {16'b0, bus.byte_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 16'h0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 8'h00, 1'b1);
        chk("post_rst_ks", {24'b0, bus.out_data}, 32'hE1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
